// File: rtl/mul_arbiter_if.sv
// Requester and multiplier-side signal bundle for mul_arbiter.
// The arbiter connects through the slave modport; clients and the multiplier use master.
interface mul_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_op2;
    logic [NUM_REQ-1:0]              resp_valid;
    logic [NUM_REQ-1:0]              resp_ready;
    logic [NUM_REQ*2*DATA_WIDTH-1:0] resp_res;
    logic [NUM_REQ-1:0]              resp_ovf;
    logic                            mul_en;
    logic [DATA_WIDTH-1:0]           mul_op1;
    logic [DATA_WIDTH-1:0]           mul_op2;
    logic [2*DATA_WIDTH-1:0]         mul_res;
    logic                            mul_overflow;

    modport slave (
        input  req_valid, req_op1, req_op2, resp_ready, mul_res, mul_overflow,
        output req_ready, resp_valid, resp_res, resp_ovf, mul_en, mul_op1, mul_op2
    );

    modport master (
        output req_valid, req_op1, req_op2, resp_ready, mul_res, mul_overflow,
        input  req_ready, resp_valid, resp_res, resp_ovf, mul_en, mul_op1, mul_op2
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier among NUM_REQ clients,
// with a tag pipe tracking result ownership and a per-client result holding register.
module mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_arbiter_if.slave bus,
    output logic         idle
);
    localparam int RES_W = 2 * DATA_WIDTH;
    localparam int TAG_W = MUL_LATENCY * ID_W;

    logic [ID_W-1:0]                      rr_q, rr_d;
    logic [NUM_REQ-1:0]                   busy_q, busy_d;
    logic [MUL_LATENCY-1:0]               tag_vld_q, tag_vld_d;
    logic [MUL_LATENCY-1:0][ID_W-1:0]     tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]                   resp_valid_q, resp_valid_d;
    logic [NUM_REQ-1:0][RES_W-1:0]        resp_res_q, resp_res_d;
    logic [NUM_REQ-1:0]                   resp_ovf_q, resp_ovf_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   op1_s, op2_s;
    logic [NUM_REQ-1:0]                   eligible_s;
    logic [NUM_REQ-1:0]                   resp_hs_s;
    logic [NUM_REQ-1:0]                   ready_s;
    logic [ID_W:0]                        scan_s;
    logic                                 hit_s;
    logic                                 grant_s;
    logic [ID_W-1:0]                      gnt_id_s;
    logic                                 cap_s;
    logic [ID_W-1:0]                      cap_id_s;

    assign op1_s = bus.req_op1;
    assign op2_s = bus.req_op2;

    // Round-robin scan starting at rr_q; picks the first requester that is valid and not busy.
    always_comb begin
        eligible_s = bus.req_valid & ~busy_q;
        grant_s    = 1'b0;
        gnt_id_s   = '0;
        scan_s     = '0;
        hit_s      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_s   = {1'b0, rr_q} + (ID_W + 1)'(k);
            scan_s   = (scan_s >= (ID_W + 1)'(NUM_REQ)) ? scan_s - (ID_W + 1)'(NUM_REQ) : scan_s;
            hit_s    = !grant_s && eligible_s[scan_s[ID_W-1:0]];
            gnt_id_s = hit_s ? scan_s[ID_W-1:0] : gnt_id_s;
            grant_s  = grant_s | hit_s;
        end
        ready_s           = '0;
        ready_s[gnt_id_s] = grant_s;
    end

    assign bus.req_ready = ready_s;
    assign bus.mul_en    = grant_s;
    assign bus.mul_op1   = grant_s ? op1_s[gnt_id_s] : '0;
    assign bus.mul_op2   = grant_s ? op2_s[gnt_id_s] : '0;

    // Next-state: issue bookkeeping, tag pipe shift, result capture and response handshake.
    always_comb begin
        resp_hs_s = resp_valid_q & bus.resp_ready;

        busy_d           = busy_q & ~resp_hs_s;
        busy_d[gnt_id_s] = busy_d[gnt_id_s] | grant_s;

        rr_d = grant_s ? ((gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1)) : rr_q;

        // The multiplier never stalls, so the tag pipe shifts unconditionally.
        tag_vld_d = MUL_LATENCY'({tag_vld_q, grant_s});
        tag_id_d  = TAG_W'({tag_id_q, gnt_id_s});

        cap_s    = tag_vld_q[MUL_LATENCY-1];
        cap_id_s = tag_id_q[MUL_LATENCY-1];

        resp_valid_d           = resp_valid_q & ~resp_hs_s;
        resp_valid_d[cap_id_s] = resp_valid_d[cap_id_s] | cap_s;
        resp_res_d             = resp_res_q;
        resp_res_d[cap_id_s]   = cap_s ? bus.mul_res : resp_res_q[cap_id_s];
        resp_ovf_d             = resp_ovf_q;
        resp_ovf_d[cap_id_s]   = cap_s ? bus.mul_overflow : resp_ovf_q[cap_id_s];
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= '0;
            busy_q       <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            resp_valid_q <= '0;
            resp_res_q   <= '0;
            resp_ovf_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            busy_q       <= busy_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            resp_valid_q <= resp_valid_d;
            resp_res_q   <= resp_res_d;
            resp_ovf_q   <= resp_ovf_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_res   = resp_res_q;
    assign bus.resp_ovf   = resp_ovf_q;
    assign idle           = ~|tag_vld_q & ~|busy_q & ~|resp_valid_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a two-stage multiplier model in the loop.
module tb_mul_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic idle;

    mul_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    mul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MUL_LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .idle  (idle)
    );

    always #5 clk = ~clk;

    logic [N-1:0][DW-1:0] op1_v, op2_v;
    assign bus.req_op1 = op1_v;
    assign bus.req_op2 = op2_v;

    function automatic logic [RW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return RW'(a) * RW'(b);
    endfunction

    function automatic logic ovf_of(input logic [RW-1:0] p);
        return |p[RW-1:DW];
    endfunction

    // Multiplier model: result valid two cycles after the issue cycle; junk when not enabled.
    logic [RW-1:0] p1_q, p2_q;
    logic          o1_q, o2_q;
    always @(posedge clk) begin
        if (bus.mul_en) begin
            p1_q <= prod(bus.mul_op1, bus.mul_op2);
            o1_q <= ovf_of(prod(bus.mul_op1, bus.mul_op2));
        end else begin
            p1_q <= {$urandom, $urandom};
            o1_q <= 1'($urandom);
        end
        p2_q <= p1_q;
        o2_q <= o1_q;
    end
    assign bus.mul_res      = p2_q;
    assign bus.mul_overflow = o2_q;

    typedef struct packed {
        logic [7:0]    id;
        logic [RW-1:0] res;
        logic          ovf;
    } sb_t;

    sb_t          sb_q[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    logic [N-1:0] granted;
    int           gcnt[N];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int find_sb(input int id);
        for (int j = 0; j < sb_q.size(); j++)
            if (int'(sb_q[j].id) == id) return j;
        return -1;
    endfunction

    task automatic monitor();
        logic [N-1:0] rdy;
        sb_t          e;
        int           idx;
        rdy     = bus.req_ready;
        granted = '0;
        if (!rst_n) return;
        check_eq("grant_onehot", 64'($countones(rdy) <= 1), 64'd1);
        if (rdy == '0) begin
            check_eq("noissue_en", 64'(bus.mul_en), 64'd0);
            check_eq("noissue_op1", 64'(bus.mul_op1), 64'd0);
            check_eq("noissue_op2", 64'(bus.mul_op2), 64'd0);
        end
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
                check_eq("grant_valid", 64'(bus.req_valid[i]), 64'd1);
                check_eq("regrant", 64'(find_sb(i) >= 0), 64'd0);
                check_eq("issue_en", 64'(bus.mul_en), 64'd1);
                check_eq("issue_op1", 64'(bus.mul_op1), 64'(op1_v[i]));
                check_eq("issue_op2", 64'(bus.mul_op2), 64'(op2_v[i]));
                granted[i] = 1'b1;
                gcnt[i]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.resp_valid[i]) begin
                idx = find_sb(i);
                check_eq("spurious_resp", 64'(idx >= 0), 64'd1);
                if (idx >= 0 && bus.resp_ready[i]) begin
                    check_eq("resp_res", bus.resp_res[i*RW +: RW], sb_q[idx].res);
                    check_eq("resp_ovf", 64'(bus.resp_ovf[i]), 64'(sb_q[idx].ovf));
                    sb_q.delete(idx);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                e.id  = 8'(i);
                e.res = prod(op1_v[i], op2_v[i]);
                e.ovf = ovf_of(e.res);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic settle();
        #1;
        monitor();
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic renew_ops();
        for (int i = 0; i < N; i++)
            if (granted[i]) begin
                op1_v[i] = $urandom;
                op2_v[i] = $urandom;
            end
    endtask

    task automatic drain();
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        for (int n = 0; n < 20 && !(idle && sb_q.size() == 0); n++) step();
        check_eq("drain_idle", 64'(idle), 64'd1);
        check_eq("drain_sb", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        adv();
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] prev_ovf;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        op1_v          = '0;
        op2_v          = '0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;

        // Reset values
        adv();
        settle();
        check_eq("rst_idle", 64'(idle), 64'd1);
        check_eq("rst_mul_en", 64'(bus.mul_en), 64'd0);
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rst_resp_ovf", 64'(bus.resp_ovf), 64'd0);
        check_eq("rst_resp_res", 64'(|bus.resp_res), 64'd0);
        adv();
        rst_n = 1'b1;

        // Single op 7*6 on requester 0
        op1_v[0] = 32'd7;
        op2_v[0] = 32'd6;
        bus.req_valid = 4'b0001;
        settle();
        check_eq("t1_ready", 64'(bus.req_ready), 64'h1);
        check_eq("t1_en", 64'(bus.mul_en), 64'd1);
        adv();
        bus.req_valid = '0;
        settle();
        check_eq("t1_early1", 64'(bus.resp_valid), 64'd0);
        adv();
        settle();
        check_eq("t1_early2", 64'(bus.resp_valid), 64'd0);
        adv();
        settle();
        check_eq("t1_valid", 64'(bus.resp_valid), 64'h1);
        check_eq("t1_res", bus.resp_res[0 +: RW], 64'd42);
        check_eq("t1_busy_idle", 64'(idle), 64'd0);
        adv();
        bus.resp_ready = 4'b0001;
        step();
        bus.resp_ready = '0;
        settle();
        check_eq("t1_cleared", 64'(bus.resp_valid), 64'd0);
        check_eq("t1_idle", 64'(idle), 64'd1);
        adv();

        // Round-robin with all requesters always valid and ready
        do_reset();
        for (int i = 0; i < N; i++) begin
            gcnt[i]  = 0;
            op1_v[i] = $urandom;
            op2_v[i] = $urandom;
        end
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        for (int t = 0; t < 100; t++) begin
            settle();
            check_eq("rr_order", 64'(bus.req_ready), 64'(1 << (t % N)));
            adv();
            renew_ops();
        end
        for (int i = 0; i < N; i++) check_eq("rr_count", 64'(gcnt[i]), 64'd25);
        drain();

        // Backpressure on requester 1
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        op1_v[1] = 32'd3;
        op2_v[1] = 32'd5;
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 4'b1101;
        settle();
        check_eq("bp_grant", 64'(bus.req_ready), 64'h2);
        adv();
        bus.req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            settle();
            check_eq("bp_no_regrant", 64'(bus.req_ready[1]), 64'd0);
            if (k >= 2) begin
                check_eq("bp_hold_valid", 64'(bus.resp_valid[1]), 64'd1);
                check_eq("bp_hold_res", bus.resp_res[RW +: RW], 64'd15);
            end
            adv();
            renew_ops();
        end
        check_eq("bp_served0", 64'(gcnt[0] >= 2), 64'd1);
        check_eq("bp_served2", 64'(gcnt[2] >= 2), 64'd1);
        check_eq("bp_served3", 64'(gcnt[3] >= 2), 64'd1);
        bus.resp_ready = '1;
        step();
        drain();

        // Same-cycle handshake and re-request on requester 2
        op1_v[2] = 32'd2;
        op2_v[2] = 32'd2;
        bus.req_valid  = 4'b0100;
        bus.resp_ready = '0;
        settle();
        check_eq("hs_grant", 64'(bus.req_ready), 64'h4);
        adv();
        bus.req_valid = '0;
        for (int n = 0; n < 10 && !bus.resp_valid[2]; n++) step();
        check_eq("hs_wait", 64'(bus.resp_valid[2]), 64'd1);
        op1_v[2] = 32'd5;
        op2_v[2] = 32'd5;
        bus.resp_ready = 4'b0100;
        bus.req_valid  = 4'b0100;
        settle();
        check_eq("hs_same_cycle", 64'(bus.req_ready[2]), 64'd0);
        adv();
        bus.resp_ready = '0;
        settle();
        check_eq("hs_next_cycle", 64'(bus.req_ready[2]), 64'd1);
        adv();
        drain();

        // Overflow passthrough on requester 0
        prev_ovf = bus.resp_ovf;
        op1_v[0] = 32'h0001_0000;
        op2_v[0] = 32'h0001_0000;
        bus.req_valid  = 4'b0001;
        bus.resp_ready = '0;
        settle();
        check_eq("ovf_grant", 64'(bus.req_ready), 64'h1);
        adv();
        bus.req_valid = '0;
        for (int n = 0; n < 10 && !bus.resp_valid[0]; n++) step();
        check_eq("ovf_wait", 64'(bus.resp_valid[0]), 64'd1);
        check_eq("ovf_own", 64'(bus.resp_ovf[0]), 64'd1);
        check_eq("ovf_others", 64'(bus.resp_ovf[3:1]), 64'(prev_ovf[3:1]));
        check_eq("ovf_res", bus.resp_res[0 +: RW], 64'h1_0000_0000);
        drain();

        // Reset one cycle after issuing to requester 3
        op1_v[3] = 32'd9;
        op2_v[3] = 32'd9;
        bus.req_valid  = 4'b1000;
        bus.resp_ready = '1;
        settle();
        check_eq("rst_issue", 64'(bus.req_ready), 64'h8);
        adv();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("mid_rst_idle", 64'(idle), 64'd1);
        check_eq("mid_rst_en", 64'(bus.mul_en), 64'd0);
        check_eq("mid_rst_res", 64'(|bus.resp_res), 64'd0);
        check_eq("mid_rst_ovf", 64'(bus.resp_ovf), 64'd0);
        sb_q.delete();
        adv();
        rst_n = 1'b1;
        op1_v[3] = 32'd4;
        op2_v[3] = 32'd4;
        bus.req_valid  = 4'b1000;
        bus.resp_ready = '0;
        settle();
        check_eq("rst_first_grant", 64'(bus.req_ready), 64'h8);
        adv();
        bus.req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            settle();
            check_eq("rst_no_old", 64'(bus.resp_valid[3]), 64'd0);
            adv();
        end
        settle();
        check_eq("rst_new_valid", 64'(bus.resp_valid[3]), 64'd1);
        check_eq("rst_new_res", bus.resp_res[3*RW +: RW], 64'd16);
        adv();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
